// File: rtl/final_register_file_pkg.sv
// final_register_file_pkg
//   Shared sizes and types for the hades-V integer register file.
//   XLEN       : architectural register width (32)
//   REG_COUNT  : number of architectural registers, x0 included (32)
//   REG_ADDR_W : width of a register index (5)
//   word_t, reg_addr_t : one register value / one register index
//   reg_array_t        : physical storage, x1..x31 only (x0 has no flops)
//   ZERO_REG           : index of the hard-wired zero register
package final_register_file_pkg;

    localparam int XLEN       = 32;
    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [XLEN-1:0]       word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Index range starts at 1 so that x0 simply does not exist in storage.
    typedef logic [REG_COUNT-1:1][XLEN-1:0] reg_array_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/final_register_file_read_port.sv
// final_register_file_read_port
//   One combinational read port of the register file.
//   Returns 0 for x0, otherwise the stored register selected by read_address.
//   Optional macro REGFILE_WRITE_BYPASS_EN: forward write_data when the
//   current write targets the register being read (write-first), except
//   while rst is asserted.
// Ports:
//   regs          in   storage array x1..x31
//   read_address  in   register index to read
//   rst           in   reset, suppresses forwarding
//   write_enable  in   write port enable (forwarding only)
//   write_address in   write port index   (forwarding only)
//   write_data    in   write port data    (forwarding only)
//   read_data     out  selected register value
module final_register_file_read_port
    import final_register_file_pkg::*;
(
    input  reg_array_t              regs,
    input  logic [REG_ADDR_W-1:0]   read_address,
    input  logic                    rst,
    input  logic                    write_enable,
    input  logic [REG_ADDR_W-1:0]   write_address,
    input  logic [XLEN-1:0]         write_data,
    output logic [XLEN-1:0]         read_data
);

    always_comb begin
        read_data = '0;
        if (read_address != ZERO_REG) begin
            read_data = regs[read_address];
`ifdef REGFILE_WRITE_BYPASS_EN
            // read_address is non-zero here, so an address match also
            // implies a non-zero write address: x0 is never forwarded.
            if (write_enable && !rst && (write_address == read_address)) begin
                read_data = write_data;
            end
`endif
        end
    end

`ifndef REGFILE_WRITE_BYPASS_EN
    // Write-port signals only matter for forwarding; fold them away here.
    logic unused_bypass_inputs;
    assign unused_bypass_inputs = ^{rst, write_enable, write_address, write_data};
`endif

endmodule

// File: rtl/final_register_file.sv
// final_register_file
//   RV32I integer register file: 31 physical 32-bit registers (x1..x31),
//   x0 reads as zero. Two combinational read ports, one clocked write port.
//   Optional macro REGFILE_WRITE_BYPASS_EN enables same-cycle write-first
//   forwarding on both read ports; default build is read-first.
// Ports:
//   clk            in   write clock
//   rst            in   asynchronous active-high reset, clears x1..x31
//   read_address1  in   rs1 index
//   read_address2  in   rs2 index
//   write_address  in   rd index
//   write_enable   in   commit write_data to write_address on posedge clk
//   write_data     in   value to write
//   read_data1     out  contents of read_address1
//   read_data2     out  contents of read_address2
module final_register_file
    import final_register_file_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] read_address1,
    input  logic [REG_ADDR_W-1:0] read_address2,
    input  logic [REG_ADDR_W-1:0] write_address,
    input  logic                  write_enable,
    input  logic [XLEN-1:0]       write_data,
    output logic [XLEN-1:0]       read_data1,
    output logic [XLEN-1:0]       read_data2
);

    reg_array_t regs;

    // Reset has priority over a coincident write; writes to x0 are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else if (write_enable && (write_address != ZERO_REG)) begin
            regs[write_address] <= write_data;
        end
    end

    final_register_file_read_port u_read_port1 (
        .regs          (regs),
        .read_address  (read_address1),
        .rst           (rst),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .read_data     (read_data1)
    );

    final_register_file_read_port u_read_port2 (
        .regs          (regs),
        .read_address  (read_address2),
        .rst           (rst),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .read_data     (read_data2)
    );

endmodule

// File: tb/tb_final_register_file.sv
// tb_final_register_file
//   Directed bench for final_register_file. An array model of the 32
//   architectural registers is updated by the driver tasks; a compare
//   process checks both read ports against it on every falling edge, and
//   hand-computed literals pin the model at key points.
//   Honours REGFILE_WRITE_BYPASS_EN for the expected forwarding behaviour.
module tb_final_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  read_address1;
    logic [4:0]  read_address2;
    logic [4:0]  write_address;
    logic        write_enable;
    logic [31:0] write_data;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model[32];
    bit          cmp_en = 1'b0;

    final_register_file dut (
        .clk           (clk),
        .rst           (rst),
        .read_address1 (read_address1),
        .read_address2 (read_address2),
        .write_address (write_address),
        .write_enable  (write_enable),
        .write_data    (write_data),
        .read_data1    (read_data1),
        .read_data2    (read_data2)
    );

    // ---------------- clock / reset ----------------
    always #50 clk = ~clk;

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        clear_model();
    endtask

    // ---------------- model ----------------
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (write_enable && !rst && (write_address == a)) return write_data;
`endif
        return model[a];
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check_next(input string name, input logic [31:0] got);
        logic [31:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: got=%h but expectation queue is empty", name, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                failures++;
                $display("FAIL %s: got=%h expected=%h", name, got, exp);
            end
        end
    endtask

    task automatic expect_lit(input string name, input logic [31:0] got, input logic [31:0] val);
        exp_q.push_back(val);
        check_next(name, got);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (read_data1 !== exp_read(read_address1)) begin
                failures++;
                $display("FAIL cmp_port1 addr=%0d: got=%h expected=%h",
                         read_address1, read_data1, exp_read(read_address1));
            end
            checks++;
            if (read_data2 !== exp_read(read_address2)) begin
                failures++;
                $display("FAIL cmp_port2 addr=%0d: got=%h expected=%h",
                         read_address2, read_data2, exp_read(read_address2));
            end
        end
    end

    // ---------------- drivers ----------------
    // Inputs change 1 time unit after posedge; the model commits at the edge.
    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        write_address = a;
        write_data    = d;
        write_enable  = 1'b1;
        @(posedge clk);
        if (!rst && a != 5'd0) model[a] = d;
        #1;
        write_enable = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst           = 1'b0;
        read_address1 = 5'd0;
        read_address2 = 5'd0;
        write_address = 5'd0;
        write_enable  = 1'b0;
        write_data    = 32'h0;
        #1;
        assert_reset();
        #1;
        cmp_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        read_address1 = 5'd1;
        read_address2 = 5'd31;
        #1;
        expect_lit("reset_x1", read_data1, 32'h0);
        expect_lit("reset_x31", read_data2, 32'h0);
        idle_cycles(1);

        // Basic write / read
        write_reg(5'd5, 32'hDEADBEEF);
        write_reg(5'd31, 32'h12345678);
        read_address1 = 5'd5;
        read_address2 = 5'd31;
        #1;
        expect_lit("basic_x5", read_data1, 32'hDEADBEEF);
        expect_lit("basic_x31", read_data2, 32'h12345678);
        read_address1 = 5'd6;
        read_address2 = 5'd30;
        #1;
        expect_lit("basic_x6_untouched", read_data1, 32'h0);
        expect_lit("basic_x30_untouched", read_data2, 32'h0);
        idle_cycles(1);

        // x0 immutability
        write_reg(5'd0, 32'hFFFFFFFF);
        read_address1 = 5'd0;
        read_address2 = 5'd0;
        #1;
        expect_lit("x0_port1", read_data1, 32'h0);
        expect_lit("x0_port2", read_data2, 32'h0);

        // write_enable low: nothing changes
        write_address = 5'd7;
        write_data    = 32'hAAAA5555;
        write_enable  = 1'b0;
        read_address1 = 5'd7;
        read_address2 = 5'd5;
        idle_cycles(3);
        expect_lit("we0_x7_holds", read_data1, 32'h0);
        expect_lit("we0_x5_holds", read_data2, 32'hDEADBEEF);

        // Fill every register, then sweep both ports across all addresses
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'h10000000 + 32'(i));
        for (int i = 0; i < 32; i++) begin
            read_address1 = 5'(i);
            read_address2 = 5'(31 - i);
            idle_cycles(1);
        end
        read_address1 = 5'd5;
        read_address2 = 5'd5;
        #1;
        expect_lit("fill_x5_port1", read_data1, 32'h10000005);
        expect_lit("fill_x5_port2", read_data2, 32'h10000005);

        // Same-cycle read and write of x10 (old 1, new 2)
        write_reg(5'd10, 32'h1);
        read_address1 = 5'd10;
        read_address2 = 5'd10;
        write_address = 5'd10;
        write_data    = 32'h2;
        write_enable  = 1'b1;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        expect_lit("rw_x10_before_p1", read_data1, 32'h2);
        expect_lit("rw_x10_before_p2", read_data2, 32'h2);
`else
        expect_lit("rw_x10_before_p1", read_data1, 32'h1);
        expect_lit("rw_x10_before_p2", read_data2, 32'h1);
`endif
        @(posedge clk);
        model[10] = 32'h2;
        #1;
        write_enable = 1'b0;
        #1;
        expect_lit("rw_x10_after_p1", read_data1, 32'h2);
        expect_lit("rw_x10_after_p2", read_data2, 32'h2);
        idle_cycles(1);

        // Mid-cycle asynchronous reset: every address reads 0 before the next edge
        write_reg(5'd12, 32'hCAFEF00D);
        assert_reset();
        for (int a = 0; a < 32; a++) begin
            read_address1 = 5'(a);
            read_address2 = 5'(31 - a);
            #1;
            expect_lit($sformatf("async_rst_p1_x%0d", a), read_data1, 32'h0);
            expect_lit($sformatf("async_rst_p2_x%0d", 31 - a), read_data2, 32'h0);
        end

        // Reset versus write: write of x3 while rst is high is lost
        idle_cycles(1);
        write_reg(5'd3, 32'h55);
        read_address1 = 5'd3;
        read_address2 = 5'd3;
        #1;
        expect_lit("rst_vs_write_x3", read_data1, 32'h0);
        rst = 1'b0;
        idle_cycles(1);
        expect_lit("rst_released_x3", read_data2, 32'h0);

        // First write after release lands
        write_reg(5'd3, 32'h55);
        #1;
        expect_lit("post_rst_write_x3", read_data1, 32'h55);
        idle_cycles(2);

        cmp_en = 1'b0;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL exp_q_drain: got=%0d leftover expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
